// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory port, with memory wait/timeout, optional MDU handshake and an illegal-op trap.
module multicycle_controller #(
  parameter logic MULDIV_EN   = 1'b1,
  parameter int   MEM_TIMEOUT = 255,
  parameter int   TO_W        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       LT,
  input  logic       LTU,
  input  logic       mem_ready,
  input  logic       mdu_done,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       mdu_start,
  output logic       fault,
  output logic [3:0] state
);

  // XWAIT hosts both MDU wait and LUI; lui_mode tells them apart.
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMREAD = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECR   = 4'd6,
    EXECI   = 4'd7,
    ALUWB   = 4'd8,
    BRANCH  = 4'd9,
    JAL     = 4'd10,
    JALR    = 4'd11,
    JALR2   = 4'd12,
    XWAIT   = 4'd13,
    TRAP    = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(MEM_TIMEOUT);
  localparam logic            TO_ON  = (MEM_TIMEOUT != 0);

  state_t          cur, nxt;
  logic            lui_mode, mdu_run, fault_q;
  logic [TO_W-1:0] wait_cnt;
  logic            waiting, timed_out, is_mdu, taken, br_bad;
  logic            pc_wr, ir_wr, mem_wr, reg_wr, start;
  logic [2:0]      imm_dec;

  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic f7b5,
                                         input logic allow_sub);
    case (f3)
      3'b000:  alu_dec = (allow_sub && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

  assign waiting   = ((cur == FETCH) || (cur == MEMREAD) || (cur == MEMWR)) && !mem_ready;
  assign timed_out = TO_ON && waiting && (wait_cnt == TO_MAX);
  assign is_mdu    = (funct7 == 7'b0000001);

  always_comb begin
    taken  = 1'b0;
    br_bad = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = LT;
      3'b101:  taken = ~LT;
      3'b110:  taken = LTU;
      3'b111:  taken = ~LTU;
      default: br_bad = 1'b1;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: imm_dec = 3'b001;
      OP_BR:    imm_dec = 3'b010;
      OP_JAL:   imm_dec = 3'b011;
      OP_LUI:   imm_dec = 3'b100;
      default:  imm_dec = 3'b000;
    endcase
  end

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:   if (mem_ready) nxt = DECODE;
               else if (timed_out) nxt = TRAP;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: nxt = MEMADR;
          OP_R:    nxt = !is_mdu ? EXECR : (MULDIV_EN ? XWAIT : TRAP);
          OP_I:    nxt = EXECI;
          OP_BR:   nxt = BRANCH;
          OP_JAL:  nxt = JAL;
          OP_JALR: nxt = JALR;
          OP_LUI:  nxt = XWAIT;
          default: nxt = TRAP;
        endcase
      end
      MEMADR:  nxt = (op == OP_STORE) ? MEMWR : MEMREAD;
      MEMREAD: if (mem_ready) nxt = MEMWB;
               else if (timed_out) nxt = TRAP;
      MEMWB:   nxt = FETCH;
      MEMWR:   if (mem_ready) nxt = FETCH;
               else if (timed_out) nxt = TRAP;
      EXECR:   nxt = ALUWB;
      EXECI:   nxt = ALUWB;
      ALUWB:   nxt = FETCH;
      BRANCH:  nxt = br_bad ? TRAP : FETCH;
      JAL:     nxt = ALUWB;
      JALR:    nxt = JALR2;
      JALR2:   nxt = ALUWB;
      XWAIT:   if (lui_mode) nxt = ALUWB;
               else if (mdu_done) nxt = FETCH;
      TRAP:    nxt = TRAP;
      default: nxt = TRAP;
    endcase
  end

  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    start      = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ImmSrc     = imm_dec;
    ALUControl = ALU_ADD;
    case (cur)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        pc_wr     = mem_ready;
        ir_wr     = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_wr    = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        mem_wr = 1'b1;
      end
      EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(funct3, funct7[5], 1'b1);
      end
      EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ImmSrc     = 3'b000;
        ALUControl = alu_dec(funct3, funct7[5], 1'b0);
      end
      ALUWB: reg_wr = 1'b1;
      BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = ALU_SUB;
        pc_wr      = taken & ~br_bad;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_wr   = 1'b1;
      end
      JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ImmSrc    = 3'b000;
        ResultSrc = 2'b10;
        pc_wr     = 1'b1;
      end
      JALR2: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      XWAIT: begin
        if (lui_mode) begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ImmSrc  = 3'b100;
        end else begin
          ResultSrc = 2'b11;
          start     = ~mdu_run;
          reg_wr    = mdu_done;
        end
      end
      default: ;
    endcase
  end

  // Strobes are suppressed while reset is asserted, whatever the state.
  assign PCWrite   = pc_wr  & ~reset;
  assign IRWrite   = ir_wr  & ~reset;
  assign MemWrite  = mem_wr & ~reset;
  assign RegWrite  = reg_wr & ~reset;
  assign mdu_start = start  & ~reset;
  assign fault     = fault_q;
  assign state     = cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur      <= FETCH;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
      lui_mode <= 1'b0;
      mdu_run  <= 1'b0;
    end else begin
      cur     <= nxt;
      fault_q <= fault_q | (nxt == TRAP);
      mdu_run <= (cur == XWAIT) && !lui_mode && (nxt == XWAIT);
      if (cur == DECODE) lui_mode <= (op == OP_LUI);
      if ((nxt != cur) || mem_ready) wait_cnt <= '0;
      else if (waiting && (wait_cnt != '1)) wait_cnt <= wait_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: table of per-cycle vectors plus hand sequences,
// expected outputs queued at drive time and compared on the falling edge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic       Zero = 1'b0, LT = 1'b0, LTU = 1'b0, mem_ready = 1'b0, mdu_done = 1'b0;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, mdu_start, fault;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl, state;

  logic       PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, mdu_start2, fault2;
  logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2;
  logic [2:0] ImmSrc2;
  logic [3:0] ALUControl2, state2;

  always #5 clk = ~clk;

  multicycle_controller #(.MULDIV_EN(1'b1), .MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .LT(LT), .LTU(LTU), .mem_ready(mem_ready), .mdu_done(mdu_done),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .mdu_start(mdu_start), .fault(fault),
    .state(state));

  multicycle_controller #(.MULDIV_EN(1'b0), .MEM_TIMEOUT(255), .TO_W(8)) dut2 (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .LT(LT), .LTU(LTU), .mem_ready(mem_ready), .mdu_done(mdu_done),
    .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
    .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .RegWrite(RegWrite2),
    .ImmSrc(ImmSrc2), .ALUControl(ALUControl2), .mdu_start(mdu_start2), .fault(fault2),
    .state(state2));

  // strobe vector order: {PCWrite, IRWrite, MemWrite, RegWrite, mdu_start}
  localparam logic [4:0] PCW = 5'b10000, IRW = 5'b01000, MW = 5'b00100, RW = 5'b00010, MS = 5'b00001;
  // mux vector: {AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl}
  localparam logic [13:0] M_ADR = 14'h2000, M_RS = 14'h1800, M_A = 14'h0600, M_B = 14'h0180;
  localparam logic [13:0] M_IMM = 14'h0070, M_ALU = 14'h000F;
  localparam int K_MDU = 16, K_MDUD = 17;

  typedef struct packed {
    logic [15:0] id;
    logic [3:0]  st;
    logic [4:0]  stb;
    logic        flt;
    logic [13:0] mv;
    logic [13:0] mm;
  } exp_t;

  typedef struct packed {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] zlt;
    logic       rdy;
    logic       done;
    exp_t       e;
  } vec_t;

  exp_t sb[$];
  exp_t ce;
  vec_t tbl[$];
  int   checks = 0, errors = 0, step = 0;
  logic [6:0] i_op, i_f7;
  logic [2:0] i_f3;

  task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, id, got, want);
    end
  endtask

  function automatic logic [13:0] pk(input logic adr, input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [2:0] im, input logic [3:0] al);
    return {adr, rs, a, b, im, al};
  endfunction

  // Expected outputs for one cycle in the state of kind k (16/17 = MDU wait / MDU done).
  function automatic exp_t mk(input int k, input logic [4:0] stb, input logic [3:0] al, input logic [2:0] im);
    exp_t e;
    e.id  = '0;
    e.st  = (k >= 16) ? 4'd13 : 4'(k);
    e.stb = stb;
    e.flt = (k == 14);
    e.mv  = '0;
    e.mm  = '0;
    case (k)
      0:  begin e.mv = pk(0, 2'b10, 2'b00, 2'b10, 3'b0, 4'h0); e.mm = M_ADR|M_RS|M_A|M_B|M_ALU; end
      1:  begin e.mv = pk(0, 2'b00, 2'b01, 2'b01, im, 4'h0);   e.mm = M_A|M_B|M_IMM|M_ALU; end
      2:  begin e.mv = pk(0, 2'b00, 2'b10, 2'b01, im, 4'h0);   e.mm = M_A|M_B|M_IMM|M_ALU; end
      3, 5: begin e.mv = pk(1, 2'b00, 2'b00, 2'b00, 3'b0, 4'h0); e.mm = M_ADR; end
      4:  begin e.mv = pk(0, 2'b01, 2'b00, 2'b00, 3'b0, 4'h0); e.mm = M_RS; end
      6:  begin e.mv = pk(0, 2'b00, 2'b10, 2'b00, 3'b0, al);   e.mm = M_A|M_B|M_ALU; end
      7:  begin e.mv = pk(0, 2'b00, 2'b10, 2'b01, 3'b0, al);   e.mm = M_A|M_B|M_IMM|M_ALU; end
      8:  begin e.mv = pk(0, 2'b00, 2'b00, 2'b00, 3'b0, 4'h0); e.mm = M_RS; end
      9:  begin e.mv = pk(0, 2'b00, 2'b10, 2'b00, 3'b0, 4'h1); e.mm = M_RS|M_A|M_B|M_ALU; end
      10: begin e.mv = pk(0, 2'b00, 2'b01, 2'b10, 3'b0, 4'h0); e.mm = M_RS|M_A|M_B; end
      11: begin e.mv = pk(0, 2'b10, 2'b10, 2'b01, 3'b0, 4'h0); e.mm = M_RS|M_A|M_B|M_IMM; end
      12: begin e.mv = pk(0, 2'b00, 2'b01, 2'b10, 3'b0, 4'h0); e.mm = M_A|M_B; end
      13: begin e.mv = pk(0, 2'b00, 2'b10, 2'b01, 3'b100, 4'h0); e.mm = M_A|M_B|M_IMM; end
      17: begin e.mv = pk(0, 2'b11, 2'b00, 2'b00, 3'b0, 4'h0); e.mm = M_RS; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic ins(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    i_op = o; i_f3 = f3; i_f7 = f7;
  endtask

  function automatic vec_t r(input logic rs, input logic [2:0] zlt, input logic rdy, input logic dn, input exp_t e);
    vec_t v;
    v.rst = rs; v.op = i_op; v.f3 = i_f3; v.f7 = i_f7;
    v.zlt = zlt; v.rdy = rdy; v.done = dn; v.e = e;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    reset = v.rst; op = v.op; funct3 = v.f3; funct7 = v.f7;
    {Zero, LT, LTU} = v.zlt; mem_ready = v.rdy; mdu_done = v.done;
    e = v.e;
    e.id = 16'(step);
    step++;
    sb.push_back(e);
  endtask

  // Fetch + decode prefix shared by every instruction.
  task automatic fd(input logic [2:0] dimm);
    tbl.push_back(r(0, 3'b000, 1, 0, mk(0, PCW|IRW, 4'h0, 3'b0)));
    tbl.push_back(r(0, 3'b000, 1, 0, mk(1, 5'b0, 4'h0, dimm)));
  endtask

  task automatic build();
    ins(7'b0110011, 3'b000, 7'b0000000);
    tbl.push_back(r(1, 3'b000, 0, 0, mk(0, 5'b0, 4'h0, 3'b0)));
    fd(3'b010);  // add
    tbl.push_back(r(0, 3'b000, 1, 0, mk(6, 5'b0, 4'h0, 3'b0)));
    tbl.push_back(r(0, 3'b000, 1, 0, mk(8, RW, 4'h0, 3'b0)));
    ins(7'b0110011, 3'b000, 7'b0100000); fd(3'b010);  // sub
    tbl.push_back(r(0, 3'b000, 0, 0, mk(6, 5'b0, 4'h1, 3'b0)));
    tbl.push_back(r(0, 3'b000, 0, 0, mk(8, RW, 4'h0, 3'b0)));
    ins(7'b0110011, 3'b011, 7'b0000000); fd(3'b010);  // sltu
    tbl.push_back(r(0, 3'b000, 0, 0, mk(6, 5'b0, 4'h9, 3'b0)));
    tbl.push_back(r(0, 3'b000, 0, 0, mk(8, RW, 4'h0, 3'b0)));
    ins(7'b0000011, 3'b010, 7'b0000000); fd(3'b010);  // lw, three wait cycles
    tbl.push_back(r(0, 3'b000, 0, 0, mk(2, 5'b0, 4'h0, 3'b000)));
    for (int i = 0; i < 3; i++) tbl.push_back(r(0, 3'b000, 0, 0, mk(3, 5'b0, 4'h0, 3'b0)));
    tbl.push_back(r(0, 3'b000, 1, 0, mk(3, 5'b0, 4'h0, 3'b0)));
    tbl.push_back(r(0, 3'b000, 0, 0, mk(4, RW, 4'h0, 3'b0)));
    ins(7'b1100011, 3'b100, 7'b0000000); fd(3'b010);  // blt taken
    tbl.push_back(r(0, 3'b010, 0, 0, mk(9, PCW, 4'h0, 3'b0)));
    ins(7'b1100011, 3'b111, 7'b0000000); fd(3'b010);  // bgeu not taken
    tbl.push_back(r(0, 3'b001, 0, 0, mk(9, 5'b0, 4'h0, 3'b0)));
    ins(7'b1100011, 3'b001, 7'b0000000); fd(3'b010);  // bne with Zero=0 taken
    tbl.push_back(r(0, 3'b011, 0, 0, mk(9, PCW, 4'h0, 3'b0)));
    ins(7'b0100011, 3'b010, 7'b0000000); fd(3'b010);  // sw, ready exactly at the timeout count
    tbl.push_back(r(0, 3'b000, 0, 0, mk(2, 5'b0, 4'h0, 3'b001)));
    for (int i = 0; i < 4; i++) tbl.push_back(r(0, 3'b000, 0, 0, mk(5, MW, 4'h0, 3'b0)));
    tbl.push_back(r(0, 3'b000, 1, 0, mk(5, MW, 4'h0, 3'b0)));
    ins(7'b0010011, 3'b101, 7'b0100000); fd(3'b010);  // srai
    tbl.push_back(r(0, 3'b000, 0, 0, mk(7, 5'b0, 4'h8, 3'b0)));
    tbl.push_back(r(0, 3'b000, 0, 0, mk(8, RW, 4'h0, 3'b0)));
    ins(7'b0010011, 3'b000, 7'b0100000); fd(3'b010);  // addi never becomes SUB
    tbl.push_back(r(0, 3'b000, 0, 0, mk(7, 5'b0, 4'h0, 3'b0)));
    tbl.push_back(r(0, 3'b000, 0, 0, mk(8, RW, 4'h0, 3'b0)));
    ins(7'b1101111, 3'b000, 7'b0000000); fd(3'b011);  // jal
    tbl.push_back(r(0, 3'b000, 0, 0, mk(10, PCW, 4'h0, 3'b0)));
    tbl.push_back(r(0, 3'b000, 0, 0, mk(8, RW, 4'h0, 3'b0)));
    ins(7'b1100111, 3'b000, 7'b0000000); fd(3'b010);  // jalr
    tbl.push_back(r(0, 3'b000, 0, 0, mk(11, PCW, 4'h0, 3'b0)));
    tbl.push_back(r(0, 3'b000, 0, 0, mk(12, 5'b0, 4'h0, 3'b0)));
    tbl.push_back(r(0, 3'b000, 0, 0, mk(8, RW, 4'h0, 3'b0)));
    ins(7'b0110111, 3'b000, 7'b0000000); fd(3'b010);  // lui
    tbl.push_back(r(0, 3'b000, 0, 0, mk(13, 5'b0, 4'h0, 3'b0)));
    tbl.push_back(r(0, 3'b000, 0, 0, mk(8, RW, 4'h0, 3'b0)));
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      ce = sb.pop_front();
      chk("state", int'(ce.id), 32'(state), 32'(ce.st));
      chk("strobes", int'(ce.id), 32'({PCWrite, IRWrite, MemWrite, RegWrite, mdu_start}), 32'(ce.stb));
      chk("fault", int'(ce.id), 32'(fault), 32'(ce.flt));
      if (ce.mm != '0)
        chk("muxes", int'(ce.id),
            32'({AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl} & ce.mm), 32'(ce.mv & ce.mm));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    build();
    @(posedge clk);  // first reset edge; second reset cycle is table row 0
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // mul: MDU launches once, writes back with mdu_done; the MDU-less instance traps.
    ins(7'b0110011, 3'b000, 7'b0000001);
    apply(r(0, 3'b000, 1, 0, mk(0, PCW|IRW, 4'h0, 3'b0)));
    apply(r(0, 3'b000, 0, 0, mk(1, 5'b0, 4'h0, 3'b010)));
    apply(r(0, 3'b000, 0, 0, mk(K_MDU, MS, 4'h0, 3'b0)));
    #2;
    chk("nomdu_state", step, 32'(state2), 32'd14);
    chk("nomdu_fault", step, 32'(fault2), 32'd1);
    for (int i = 0; i < 4; i++) apply(r(0, 3'b000, 0, 0, mk(K_MDU, 5'b0, 4'h0, 3'b0)));
    apply(r(0, 3'b000, 0, 1, mk(K_MDUD, RW, 4'h0, 3'b0)));
    apply(r(1, 3'b000, 0, 0, mk(0, 5'b0, 4'h0, 3'b0)));
    #2;
    chk("nomdu_sticky", step, 32'(fault2), 32'd1);

    // Fetch timeout: five wait cycles, then TRAP held regardless of mem_ready.
    for (int i = 0; i < 5; i++) apply(r(0, 3'b000, 0, 0, mk(0, 5'b0, 4'h0, 3'b0)));
    #2;
    chk("nomdu_reset", step, 32'(fault2), 32'd0);
    apply(r(0, 3'b000, 1, 0, mk(14, 5'b0, 4'h0, 3'b0)));
    apply(r(0, 3'b000, 1, 0, mk(14, 5'b0, 4'h0, 3'b0)));
    apply(r(1, 3'b000, 0, 0, mk(14, 5'b0, 4'h0, 3'b0)));

    // Reset while MemWrite is high, then a full-length fetch wait.
    ins(7'b0100011, 3'b010, 7'b0000000);
    apply(r(0, 3'b000, 1, 0, mk(0, PCW|IRW, 4'h0, 3'b0)));
    apply(r(0, 3'b000, 0, 0, mk(1, 5'b0, 4'h0, 3'b010)));
    apply(r(0, 3'b000, 0, 0, mk(2, 5'b0, 4'h0, 3'b001)));
    apply(r(0, 3'b000, 0, 0, mk(5, MW, 4'h0, 3'b0)));
    apply(r(1, 3'b000, 0, 0, mk(5, 5'b0, 4'h0, 3'b0)));
    for (int i = 0; i < 4; i++) apply(r(0, 3'b000, 0, 0, mk(0, 5'b0, 4'h0, 3'b0)));
    apply(r(0, 3'b000, 1, 0, mk(0, PCW|IRW, 4'h0, 3'b0)));

    // Illegal opcode.
    ins(7'b0000000, 3'b000, 7'b0000000);
    apply(r(0, 3'b000, 0, 0, mk(1, 5'b0, 4'h0, 3'b010)));
    apply(r(0, 3'b000, 1, 0, mk(14, 5'b0, 4'h0, 3'b0)));
    apply(r(0, 3'b000, 1, 0, mk(14, 5'b0, 4'h0, 3'b0)));

    @(negedge clk);
    #1;
    chk("drain", step, 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
